// File: rtl/pipelined_adder.sv
// Pipelined carry-chain adder/subtractor, one WIDTH/STAGES-bit slice per stage.
// Carry, operands and finished sum slices travel with each op under valid/ready.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;
    localparam int LAST  = STAGES - 1;

    logic                          adv;
    logic [STAGES-1:0]             v_q;
    logic [STAGES-1:0]             c_q;
    logic [STAGES-1:0][WIDTH-1:0]  a_q;
    logic [STAGES-1:0][WIDTH-1:0]  b_q;
    logic [STAGES-1:0][WIDTH-1:0]  s_q;
    logic                          ovf_q;

    logic [STAGES-1:0]             v_d;
    logic [STAGES-1:0]             c_d;
    logic [STAGES-1:0][WIDTH-1:0]  a_d;
    logic [STAGES-1:0][WIDTH-1:0]  b_d;
    logic [STAGES-1:0][WIDTH-1:0]  s_d;
    logic                          ovf_d;
    logic [SLICE:0]                t;

    // Operands of the last stage are never read again after the final slice.
    logic unused_q;
    assign unused_q = ^{a_q[LAST], b_q[LAST]};

    // Whole pipe moves together; it only holds when a result is waiting.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = ovf_q;

    // Next-state of every stage: add its own slice on top of the incoming op.
    always_comb begin
        v_d   = '0;
        c_d   = '0;
        a_d   = '0;
        b_d   = '0;
        s_d   = '0;
        t     = '0;
        ovf_d = 1'b0;

        v_d[0] = in_valid;
        a_d[0] = a;
        b_d[0] = sub ? ~b : b;
        t = {1'b0, a_d[0][SLICE-1:0]}
          + {1'b0, b_d[0][SLICE-1:0]}
          + {{SLICE{1'b0}}, sub | c_in};
        s_d[0][SLICE-1:0] = t[SLICE-1:0];
        c_d[0] = t[SLICE];

        for (int k = 1; k < STAGES; k++) begin
            v_d[k] = v_q[k-1];
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            t = {1'b0, a_d[k][k*SLICE +: SLICE]}
              + {1'b0, b_d[k][k*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, c_q[k-1]};
            s_d[k][k*SLICE +: SLICE] = t[SLICE-1:0];
            c_d[k] = t[SLICE];
        end

        ovf_d = (a_d[LAST][MSB] == b_d[LAST][MSB])
             && (s_d[LAST][MSB] != a_d[LAST][MSB]);
    end

    // Stage registers; reset flushes every in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for the 8/2 adder plus random streams at 32/4 and 32/1.
// Expected results come from hand values and an independent 33-bit model.
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv8, ir8, ov8, or8, ci8, sb8, c8, o8;
    logic [7:0] a8, b8, s8;

    logic        iv4, ir4, ov4, or4, ci4, sb4, c4, o4;
    logic [31:0] a4, b4, s4;

    logic        iv1, ir1, ov1, or1, ci1, sb1, c1, o1;
    logic [31:0] a1, b1, s1;

    int vec  = 0;
    int errs = 0;

    logic [33:0] q4[$];
    logic [33:0] q1[$];

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .c_in(ci8), .sub(sb8),
        .out_valid(ov8), .out_ready(or8),
        .s(s8), .c_out(c8), .ovf(o8)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .c_in(ci4), .sub(sb4),
        .out_valid(ov4), .out_ready(or4),
        .s(s4), .c_out(c4), .ovf(o4)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .c_in(ci1), .sub(sb1),
        .out_valid(ov1), .out_ready(or1),
        .s(s1), .c_out(c1), .ovf(o1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic ci, input logic sb);
        logic [31:0] yp;
        logic [32:0] r;
        logic        v;
        yp = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yp} + {32'd0, (sb ? 1'b1 : ci)};
        v  = (x[31] == yp[31]) && (r[31] != x[31]);
        return {v, r};
    endfunction

    task automatic op8(input string tag, input logic [7:0] x,
                       input logic [7:0] y, input logic ci,
                       input logic sb, input logic [7:0] es,
                       input logic ec, input logic eo);
        @(posedge clk); #1;
        iv8 = 1'b1; a8 = x; b8 = y; ci8 = ci; sb8 = sb; or8 = 1'b1;
        chk({tag, "_rdy"}, 64'(ir8), 64'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk({tag, "_lat"}, 64'(ov8), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_v"}, 64'(ov8), 64'd1);
        chk({tag, "_res"}, 64'({o8, c8, s8}), 64'({eo, ec, es}));
    endtask

    initial begin
        int sent, got, cyc;
        logic stall_prev;
        logic [7:0] held;
        logic [33:0] e;

        iv8 = 0; or8 = 1; a8 = 0; b8 = 0; ci8 = 0; sb8 = 0;
        iv4 = 0; or4 = 1; a4 = 0; b4 = 0; ci4 = 0; sb4 = 0;
        iv1 = 0; or1 = 1; a1 = 0; b1 = 0; ci1 = 0; sb1 = 0;

        // reset with an op offered
        rst_n = 1'b0;
        iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ov8), 64'd0);
        chk("rst_s", 64'(s8), 64'd0);
        chk("rst_cout", 64'(c8), 64'd0);
        chk("rst_ovf", 64'(o8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        iv8 = 1'b0;
        #1;
        chk("rst_inready", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        chk("rst_idle", 64'(ov8), 64'd0);

        // carry across the slice boundary, subtraction, overflow
        op8("add_0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        op8("add_ff00c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("sub_0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("add_7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // back-pressure stream
        @(posedge clk); #1;
        sent = 0; got = 0; cyc = 0;
        stall_prev = 1'b0; held = '0;
        while (got < 8 && cyc < 80) begin
            iv8 = (sent < 8);
            a8 = 8'(sent + 1);
            b8 = 8'(sent + 1);
            ci8 = 1'b0; sb8 = 1'b0;
            or8 = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            if (stall_prev) begin
                chk("bp_hold_v", 64'(ov8), 64'd1);
                chk("bp_hold_s", 64'(s8), 64'(held));
            end
            if (ov8 && !or8) chk("bp_inready", 64'(ir8), 64'd0);
            if (ov8 && or8) begin
                chk("bp_result", 64'(s8), 64'(2 * (got + 1)));
                got++;
            end
            stall_prev = ov8 && !or8;
            held = s8;
            if (iv8 && ir8) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        iv8 = 1'b0; or8 = 1'b1;
        chk("bp_got", 64'(got), 64'd8);
        chk("bp_sent", 64'(sent), 64'd8);
        chk("bp_nodup", 64'(ov8), 64'd0);

        // reset with two ops in flight
        @(posedge clk); #1;
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; or8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h03; b8 = 8'h04;
        @(posedge clk); #1;
        iv8 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async", 64'(ov8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_flush", 64'(ov8), 64'd0);
        end
        op8("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        @(posedge clk); #1;

        // random streams at 32/4 and 32/1
        for (int i = 0; i < 10008; i++) begin
            if (i < 10000) begin
                iv4 = ($urandom_range(3) != 0);
                or4 = ($urandom_range(2) != 0);
                a4 = $urandom; b4 = $urandom;
                ci4 = 1'($urandom); sb4 = 1'($urandom);
                iv1 = ($urandom_range(3) != 0);
                or1 = ($urandom_range(2) != 0);
                a1 = $urandom; b1 = $urandom;
                ci1 = 1'($urandom); sb1 = 1'($urandom);
            end else begin
                iv4 = 1'b0; or4 = 1'b1;
                iv1 = 1'b0; or1 = 1'b1;
            end
            @(negedge clk);
            if (ov4 && or4) begin
                chk("r4_pending", 64'(q4.size() > 0), 64'd1);
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    chk("r4_result", 64'({o4, c4, s4}), 64'(e));
                end
            end
            if (iv4 && ir4) q4.push_back(model(a4, b4, ci4, sb4));
            if (ov1 && or1) begin
                chk("r1_pending", 64'(q1.size() > 0), 64'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("r1_result", 64'({o1, c1, s1}), 64'(e));
                end
            end
            if (iv1 && ir1) q1.push_back(model(a1, b1, ci1, sb1));
            @(posedge clk); #1;
        end
        chk("r4_drained", 64'(q4.size()), 64'd0);
        chk("r1_drained", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
